// File: rtl/uart_tx.sv
// UART transmitter: start bit, 5..8 data bits LSB first, optional parity, one stop bit.
// Parity generation is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] baud_div,
  input  logic [3:0]            data_bits,
  input  logic                  parity_en,
  input  logic                  odd_parity,
  input  logic                  send,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx,
  output logic                  busy,
  output logic                  data_bits_error,
  output logic                  done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif

  logic [2:0]            state;
  logic [DATA_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] div_m1;
  logic [7:0]            shreg;
  logic [3:0]            nbits;
  logic [2:0]            bit_idx;
  logic                  tx_q;
  logic                  done_q;
  logic                  err_q;

  logic                  legal;
  logic [DATA_WIDTH-1:0] load_div;
  logic                  last_bit;
  logic                  cnt_zero;
  logic                  unused_bits;

`ifdef UART_TX_PARITY_EN
  logic       par_en_q;
  logic       par_bit_q;
  logic [7:0] mask;
  logic       par_calc;

  // Only the bits actually sent contribute to parity.
  always_comb begin
    mask     = 8'hFF >> (4'd8 - data_bits);
    par_calc = (^(tx_data[7:0] & mask)) ^ odd_parity;
  end
  assign unused_bits = ^tx_data[DATA_WIDTH-1:8];
`else
  assign unused_bits = ^{tx_data[DATA_WIDTH-1:8], parity_en, odd_parity};
`endif

  always_comb begin
    legal    = (data_bits >= 4'd5) && (data_bits <= 4'd8);
    load_div = (baud_div == '0) ? '0 : baud_div - DATA_WIDTH'(1);
    last_bit = ({1'b0, bit_idx} == (nbits - 4'd1));
    cnt_zero = (cnt == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      div_m1  <= '0;
      shreg   <= '0;
      nbits   <= '0;
      bit_idx <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (send) begin
            if (legal) begin
              state  <= START;
              cnt    <= load_div;
              div_m1 <= load_div;
              shreg  <= tx_data[7:0];
              nbits  <= data_bits;
              tx_q   <= 1'b0;
              err_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
              par_en_q  <= parity_en;
              par_bit_q <= par_calc;
`endif
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        START: begin
          if (cnt_zero) begin
            state   <= DATA;
            cnt     <= div_m1;
            bit_idx <= '0;
            tx_q    <= shreg[0];
          end else begin
            cnt <= cnt - DATA_WIDTH'(1);
          end
        end
        DATA: begin
          if (cnt_zero) begin
            cnt <= div_m1;
            if (last_bit) begin
`ifdef UART_TX_PARITY_EN
              if (par_en_q) begin
                state <= PARITY;
                tx_q  <= par_bit_q;
              end else begin
                state <= STOP;
                tx_q  <= 1'b1;
              end
`else
              state <= STOP;
              tx_q  <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= shreg >> 1;
              tx_q    <= shreg[1];
            end
          end else begin
            cnt <= cnt - DATA_WIDTH'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (cnt_zero) begin
            state <= STOP;
            cnt   <= div_m1;
            tx_q  <= 1'b1;
          end else begin
            cnt <= cnt - DATA_WIDTH'(1);
          end
        end
`endif
        STOP: begin
          if (cnt_zero) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end else begin
            cnt <= cnt - DATA_WIDTH'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

  assign tx              = tx_q;
  assign busy            = (state != IDLE);
  assign done            = done_q;
  assign data_bits_error = err_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx; expected frames are hand-computed bit strings
// (time order, bit 0 = start bit), selected per UART_TX_PARITY_EN build.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] baud_div = '0;
  logic [3:0]  data_bits = '0;
  logic        parity_en = 1'b0;
  logic        odd_parity = 1'b0;
  logic        send = 1'b0;
  logic [31:0] tx_data = '0;
  logic        tx, busy, data_bits_error, done;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  uart_tx #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .data_bits(data_bits),
    .parity_en(parity_en), .odd_parity(odd_parity), .send(send),
    .tx_data(tx_data), .tx(tx), .busy(busy),
    .data_bits_error(data_bits_error), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Launch one frame and check tx/busy every cycle, then the done cycle.
  // hold=0: inputs are scrambled and a bogus send issued mid-frame (must be ignored).
  // hold=1: send stays high, so a second frame must start in the done cycle.
  task automatic run_frame(input string tag, input logic [31:0] div, input logic [3:0] nb,
                           input logic pe, input logic od, input logic [31:0] data,
                           input int unsigned len, input logic [15:0] exp_bits, input bit hold);
    int unsigned b;
    bit seen;
    b = (div == 0) ? 1 : div;
    @(negedge clk);
    baud_div = div; data_bits = nb; parity_en = pe; odd_parity = od; tx_data = data; send = 1'b1;
    @(negedge clk);
    check({tag, "_err_clr"}, data_bits_error, 1'b0);
    if (!hold) begin
      data_bits = 4'd9; tx_data = ~data; baud_div = 32'd7; parity_en = ~pe; odd_parity = ~od;
    end
    for (int unsigned k = 0; k < len * b; k++) begin
      check({tag, "_tx"}, tx, exp_bits[k / b]);
      check({tag, "_busy"}, busy, 1'b1);
      if (k == 2 && !hold) send = 1'b0;
      @(negedge clk);
    end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_idle_tx"}, tx, 1'b1);
    check({tag, "_err_keep"}, data_bits_error, 1'b0);
    @(negedge clk);
    check({tag, "_done_1cyc"}, done, 1'b0);
    if (hold) begin
      check({tag, "_b2b_busy"}, busy, 1'b1);
      check({tag, "_b2b_tx"}, tx, 1'b0);
      send = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      check({tag, "_b2b_done"}, seen, 1'b1);
    end
  endtask

  initial begin
    bit any_done;
    bit any_busy;

    repeat (2) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", data_bits_error, 1'b0);
    rst = 1'b0;

`ifdef UART_TX_PARITY_EN
    run_frame("odd55", 32'd4, 4'd8, 1'b1, 1'b1, 32'h55, 11, 16'b110_1010_1010, 1'b0);
    run_frame("even55", 32'd4, 4'd8, 1'b1, 1'b0, 32'h55, 11, 16'b100_1010_1010, 1'b0);
`else
    run_frame("odd55", 32'd4, 4'd8, 1'b1, 1'b1, 32'h55, 10, 16'b10_1010_1010, 1'b0);
    run_frame("even55", 32'd4, 4'd8, 1'b1, 1'b0, 32'h55, 10, 16'b10_1010_1010, 1'b0);
`endif
    run_frame("nopar55", 32'd4, 4'd8, 1'b0, 1'b1, 32'h55, 10, 16'b10_1010_1010, 1'b0);

    // Illegal width is rejected and leaves the line idle.
    @(negedge clk);
    data_bits = 4'd9; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    check("rej_err", data_bits_error, 1'b1);
    any_done = 1'b0; any_busy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (done) any_done = 1'b1;
      if (busy || !tx) any_busy = 1'b1;
      @(negedge clk);
    end
    check("rej_no_done", any_done, 1'b0);
    check("rej_no_frame", any_busy, 1'b0);
    check("rej_err_hold", data_bits_error, 1'b1);

    // 6 data bits from 0x2D; upper garbage bits must not reach the line or the parity.
`ifdef UART_TX_PARITY_EN
    run_frame("w6", 32'd2, 4'd6, 1'b1, 1'b0, 32'hFFFF_FFAD, 9, 16'b1_0101_1010, 1'b0);
`else
    run_frame("w6", 32'd2, 4'd6, 1'b1, 1'b0, 32'hFFFF_FFAD, 8, 16'b1101_1010, 1'b0);
`endif

    run_frame("div0", 32'd0, 4'd5, 1'b0, 1'b0, 32'h1F, 7, 16'b111_1110, 1'b1);

    // Abort mid-DATA with all-zero payload: tx must jump high without a clock edge.
    @(negedge clk);
    baud_div = 32'd4; data_bits = 4'd8; parity_en = 1'b0; tx_data = 32'h00; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_pre_tx", tx, 1'b0);
    check("abort_pre_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("abort_tx", tx, 1'b1);
    check("abort_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    any_done = 1'b0; any_busy = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) any_done = 1'b1;
      if (busy || !tx) any_busy = 1'b1;
    end
    check("abort_no_done", any_done, 1'b0);
    check("abort_idle", any_busy, 1'b0);

`ifdef UART_TX_PARITY_EN
    run_frame("post_rst", 32'd4, 4'd8, 1'b1, 1'b1, 32'h55, 11, 16'b110_1010_1010, 1'b0);
`else
    run_frame("post_rst", 32'd4, 4'd8, 1'b1, 1'b1, 32'h55, 10, 16'b10_1010_1010, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of baud_div and tx_data (matches the UART CSR data width).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port baud_div  input  DATA_WIDTH  clk cycles per serial bit (baud-rate CSR value).
REQ-005 SHALL have port data_bits  input  4  data bits per frame (control_0 field).
REQ-006 SHALL have port parity_en  input  1  1 = parity bit appended (control_0 parity_bit).
REQ-007 SHALL have port odd_parity  input  1  1 = odd parity, 0 = even (control_0 odd_parity).
REQ-008 SHALL have port send  input  1  start request (control_0 send_data).
REQ-009 SHALL have port tx_data  input  DATA_WIDTH  payload (send-data CSR); only bits [data_bits-1:0] are used.
REQ-010 SHALL have port tx  output  1  serial line, idle high.
REQ-011 SHALL have port busy  output  1  frame in progress (status_0 busy).
REQ-012 SHALL have port data_bits_error  output  1  last request rejected for illegal data_bits (status_0 field).
REQ-013 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-015 In IDLE, send=1 with 5<=data_bits<=8 SHALL be accepted at that clock edge: capture tx_data, data_bits, parity_en, odd_parity, baud_div; go to START; clear data_bits_error.
REQ-016 In IDLE, send=1 with data_bits outside 5..8 SHALL be rejected: stay IDLE, set data_bits_error=1, no frame, no done.
REQ-017 send while busy=1 SHALL be ignored, with no effect on the frame or on data_bits_error.
REQ-018 Input changes after acceptance SHALL NOT affect the frame in progress.
REQ-019 Each state SHALL last exactly B cycles, where B = captured baud_div, or 1 if baud_div==0; counter loads B-1, decrements to 0, then advances.
REQ-020 tx SHALL be 0 in START, data bit i (LSB first) in DATA, the parity bit in PARITY, and 1 in STOP and IDLE.
REQ-021 DATA SHALL emit exactly the captured data_bits bits, then go to PARITY if parity_en, else to STOP.
REQ-022 The parity bit SHALL be the XOR of the sent data bits, inverted when odd_parity=1, so the count of ones over data plus parity is odd (odd) or even (even).
REQ-023 tx SHALL be registered; the first START cycle on tx SHALL be the cycle after the accepting edge.
REQ-024 busy SHALL be 1 for every cycle the FSM is outside IDLE; frame length = (2 + data_bits + parity_en) * B cycles.
REQ-025 After the last STOP cycle the FSM SHALL return to IDLE, and done SHALL be 1 for exactly that first IDLE cycle.
REQ-026 send=1 in the done cycle SHALL be accepted (back-to-back frames, single idle cycle between).

Reset
REQ-027 On rst=1, asynchronously: state=IDLE, tx=1, busy=0, done=0, data_bits_error=0, counters and captured data cleared.
REQ-028 rst asserted mid-frame SHALL abort the frame; tx returns high immediately, and no done pulse follows.
REQ-029 After rst deasserts, the first send SHALL be evaluated on the first rising edge with rst=0.

Configuration
REQ-030 Macro UART_TX_PARITY_EN defined: parity generation per REQ-021/022.
REQ-031 Macro UART_TX_PARITY_EN undefined: PARITY state and parity logic removed, parity_en and odd_parity ignored (ports retained), frame length = (2 + data_bits) * B.

Verification
REQ-032 baud_div=4, data_bits=8, parity_en=1, odd_parity=1, tx_data=0x55, send pulse -> tx = 0,1,0,1,0,1,0,1,0,1(parity),1(stop), each 4 cycles; busy high 44 cycles; done one pulse.
REQ-033 Same frame with odd_parity=0 -> parity bit 0; parity_en=0 -> 10-bit frame, busy 40 cycles.
REQ-034 data_bits=9, send -> tx stays 1, busy stays 0, data_bits_error=1; next send with data_bits=8 -> data_bits_error=0.
REQ-035 baud_div=0, data_bits=5, parity_en=0, tx_data=0x1F -> 7-cycle frame 0,1,1,1,1,1,1; send held high throughout is ignored until done; then a new frame starts in the done cycle.
REQ-036 rst pulse during DATA of a baud_div=4 frame -> tx=1, busy=0 asynchronously; no done; next send produces a complete, correct frame.
